// File: rtl/seg_display_seq_if.sv
// seg_display_seq_if: request/status bundle between the score logic
// and the sequential seven-segment display driver.
interface seg_display_seq_if #(
  parameter int BIN_W       = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int CHAR_DIGITS = 2
);
  // a zero-character build still carries a 1-bit unused field
  localparam int CIW = (CHAR_DIGITS > 0) ? 7 * CHAR_DIGITS : 1;
  localparam int HW  = 8 * (NUM_DIGITS + CHAR_DIGITS);

  logic             START;
  logic [BIN_W-1:0] NUM_INPUT;
  logic [CIW-1:0]   CHAR_INPUT;
  logic             LZB;
  logic             BLINK_EN;
  logic             BUSY;
  logic             DONE;
  logic             OVF;
  logic [HW-1:0]    HEX_OUT;

  modport master (
    output START, NUM_INPUT, CHAR_INPUT, LZB, BLINK_EN,
    input  BUSY, DONE, OVF, HEX_OUT
  );

  modport slave (
    input  START, NUM_INPUT, CHAR_INPUT, LZB, BLINK_EN,
    output BUSY, DONE, OVF, HEX_OUT
  );
endinterface

// File: rtl/seg_display_seq.sv
// seg_display_seq: captures a value, converts it to BCD one bit per
// clock (double dabble) and drives registered seven-segment outputs.
module seg_display_seq #(
  parameter int BIN_W       = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int CHAR_DIGITS = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input logic              CLK,
  input logic              RST,
  seg_display_seq_if.slave bus
);
  // ceil(BIN_W * log10(2)); 2^BIN_W is never a power of ten
  localparam int DI  = (BIN_W * 301030 + 999999) / 1000000;
  localparam int DB  = (DI > NUM_DIGITS) ? DI : NUM_DIGITS;
  localparam int ND  = NUM_DIGITS;
  localparam int CD  = CHAR_DIGITS;
  localparam int HW  = 8 * (ND + CD);
  localparam int CIW = (CD > 0) ? 7 * CD : 1;
  localparam int CDW = (CD > 0) ? 8 * CD : 8;
  localparam int CW  = $clog2(BIN_W + 1);
  localparam int PW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_e;

  state_e state_q, state_d;

  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [4*DB-1:0]   bcd_q, bcd_d;
  logic [4*DB-1:0]   adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CIW-1:0]    chr_q, chr_d;
  logic              lzb_q, lzb_d;
  logic [8*ND-1:0]   num_q, num_d;
  logic [CDW-1:0]    chd_q, chd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              ph_q, ph_d;
  logic [HW-1:0]     hex_q, hex_d;

  logic              busy;
  logic              ovf_c;
  logic              seen;
  logic [3:0]        dig;
  logic [8*ND-1:0]   pat_c;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = CONV;
      CONV:    if (cnt_q == CW'(BIN_W - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done_d = (state_q == FINISH);
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DB; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    chr_d = chr_q;
    lzb_d = lzb_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          bin_d = bus.NUM_INPUT;
          bcd_d = '0;
          cnt_d = '0;
          chr_d = bus.CHAR_INPUT;
          lzb_d = bus.LZB;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {adj[4*DB-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // digit patterns from the finished BCD word
  always_comb begin
    ovf_c = 1'b0;
    for (int i = ND; i < DB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
    seen  = 1'b0;
    dig   = 4'd0;
    pat_c = '1;
    for (int i = ND - 1; i >= 0; i--) begin
      dig = bcd_q[4*i +: 4];
      if (dig != 4'd0) seen = 1'b1;
      if (ovf_c)                        pat_c[8*i +: 8] = 8'hBF;
      else if (lzb_q && !seen && i != 0) pat_c[8*i +: 8] = 8'hFF;
      else                              pat_c[8*i +: 8] = seg7(dig);
    end
  end

  always_comb begin
    num_d = num_q;
    chd_d = chd_q;
    ovf_d = ovf_q;
    if (state_q == FINISH) begin
      num_d = pat_c;
      ovf_d = ovf_c;
      for (int i = 0; i < CD; i++) begin
        chd_d[8*i +: 8] = {1'b1, chr_q[7*i +: 7]};
      end
    end
  end

  always_comb begin
    pre_d = pre_q;
    ph_d  = ph_q;
    if (!bus.BLINK_EN) begin
      pre_d = '0;
      ph_d  = 1'b1;
    end else if (pre_q == PW'(BLINK_DIV - 1)) begin
      pre_d = '0;
      ph_d  = ~ph_q;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // built from next-state values so digits and phase land on one edge
  always_comb begin
    hex_d = '1;
    for (int i = 0; i < ND; i++) begin
      hex_d[8*i +: 8] = ph_d ? num_d[8*i +: 8] : 8'hFF;
    end
    for (int i = 0; i < CD; i++) begin
      hex_d[8*(ND+i) +: 8] = chd_d[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      chr_q  <= '0;
      lzb_q  <= 1'b0;
      num_q  <= '1;
      chd_q  <= '1;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      pre_q  <= '0;
      ph_q   <= 1'b1;
      hex_q  <= '1;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      chr_q  <= chr_d;
      lzb_q  <= lzb_d;
      num_q  <= num_d;
      chd_q  <= chd_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      pre_q  <= pre_d;
      ph_q   <= ph_d;
      hex_q  <= hex_d;
    end
  end

  assign bus.BUSY    = busy;
  assign bus.DONE    = done_q;
  assign bus.OVF     = ovf_q;
  assign bus.HEX_OUT = hex_q;
endmodule
